// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: turns one single-cycle SRAM-style core port into a
// split-transaction request/response handshake, generates the core stall
// for that port and applies fixed kseg0/kseg1 translation.
module cpu_mem_bridge #(
  parameter bit TRANSLATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  // request as it would be issued from the current core inputs
  logic        in_wr;
  logic [1:0]  in_size;
  logic [31:0] in_paddr;
  logic [31:0] in_addr;

  // decode core access into size/strobe and the physical address
  always_comb begin
    in_wr    = |cpu_wen;
    in_paddr = cpu_addr;
    if (TRANSLATE && (cpu_addr[31:29] == 3'b100 || cpu_addr[31:29] == 3'b101))
      in_paddr = {3'b000, cpu_addr[28:0]};
    in_addr = in_paddr;
    in_size = 2'd2;
    if (in_wr) begin
      case (cpu_wen)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: in_size = 2'd0;
        4'b0011, 4'b1100:                   in_size = 2'd1;
        default:                            in_size = 2'd2;  // word or illegal mix
      endcase
    end else begin
      in_addr[1:0] = 2'b00;  // reads are always whole words
    end
  end

  // next-state, latch update and read-data capture
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_en) begin
          state_d = mem_addr_ok ? S_WAIT : S_REQ;
          wr_d    = in_wr;
          size_d  = in_size;
          wstrb_d = cpu_wen;
          addr_d  = in_addr;
          wdata_d = cpu_wdata;
        end
      end
      S_REQ:  if (mem_addr_ok) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_data_ok) begin
          state_d = S_DONE;
          rdata_d = mem_rdata;
        end
      end
      S_DONE: state_d = S_IDLE;  // release cycle, core advances here
      default: state_d = S_IDLE;
    endcase
  end

  // memory-side outputs: live from the core in IDLE, latched afterwards
  always_comb begin
    if (state_q == S_IDLE) begin
      mem_wr    = in_wr;
      mem_size  = in_size;
      mem_wstrb = cpu_wen;
      mem_addr  = in_addr;
      mem_wdata = cpu_wdata;
    end else begin
      mem_wr    = wr_q;
      mem_size  = size_q;
      mem_wstrb = wstrb_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    mem_req   = (state_q == S_IDLE && cpu_en) || (state_q == S_REQ);
    stall     = cpu_en && (state_q != S_DONE);
    cpu_rdata = rdata_q;
  end

  // state and latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: table of accesses run back-to-back against a
// timed memory model, request/response scoreboards, plus reset corner cases.
module tb_cpu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        stall, mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;

  logic [31:0] n_cpu_rdata, n_mem_addr, n_mem_wdata;
  logic        n_stall, n_mem_req, n_mem_wr;
  logic [1:0]  n_mem_size;
  logic [3:0]  n_mem_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_mem_bridge #(.TRANSLATE(1'b1)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata));

  cpu_mem_bridge #(.TRANSLATE(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(n_cpu_rdata),
    .stall(n_stall), .mem_req(n_mem_req), .mem_wr(n_mem_wr), .mem_size(n_mem_size),
    .mem_wstrb(n_mem_wstrb), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata));

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw;      // cycles mem_req waits before addr_ok
    int          dw;      // extra WAIT cycles before data_ok
    bit          stray;   // pulse data_ok where it must be ignored
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_addr_nt;
    logic [1:0]  exp_size;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] addr_nt;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // one access with cpu_en held; returns at the negedge after DONE
  task automatic run_access(input vec_t v);
    req_t r;
    int   dcyc, stalls, reqs;
    bit   done;
    r.wr = |v.wen; r.size = v.exp_size; r.wstrb = v.wen;
    r.addr = v.exp_addr; r.addr_nt = v.exp_addr_nt; r.wdata = v.wdata;
    req_q.push_back(r);
    rsp_q.push_back(v.rdata);
    cpu_en = 1'b1; cpu_wen = v.wen; cpu_addr = v.addr; cpu_wdata = v.wdata;
    dcyc = v.aw + 1 + v.dw;
    stalls = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_addr_ok = (c == v.aw);
      mem_data_ok = (c == dcyc) || (v.stray && (c <= v.aw || c == dcyc + 1));
      mem_rdata   = (c == dcyc) ? v.rdata : 32'hDEAD_BEEF;
      #1;
      if (stall) stalls++;
      if (mem_req) reqs++;
      if (mem_req && mem_addr_ok) begin
        if (req_q.size() == 0) begin
          chk("extra_issue", 32'd1, 32'd0);
        end else begin
          r = req_q.pop_front();
          chk("mem_wr", {31'd0, mem_wr}, {31'd0, r.wr});
          chk("mem_size", {30'd0, mem_size}, {30'd0, r.size});
          chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, r.wstrb});
          chk("mem_addr", mem_addr, r.addr);
          chk("mem_addr_notrans", n_mem_addr, r.addr_nt);
          if (r.wr) chk("mem_wdata", mem_wdata, r.wdata);
        end
      end
      if (!stall) begin
        done = 1'b1;
        chk("cpu_rdata", cpu_rdata, rsp_q.pop_front());
        chk("done_mem_req", {31'd0, mem_req}, 32'd0);
        chk("stall_cycles", stalls, v.aw + v.dw + 2);
        chk("req_cycles", reqs, v.aw + 1);
      end
      @(negedge clk);
    end
    if (!done) chk("timeout_done", 32'd0, 32'd1);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'b0000, 32'hBFC0_0004, 32'h0,         0, 0, 0, 32'h1234_5678, 32'h1FC0_0004, 32'hBFC0_0004, 2'd2};
    tbl[1] = '{4'b0100, 32'h8000_0012, 32'h00AB_0000, 3, 1, 0, 32'h0000_0001, 32'h0000_0012, 32'h8000_0012, 2'd0};
    tbl[2] = '{4'b1100, 32'h0000_1002, 32'hCAFE_0000, 1, 0, 0, 32'h0000_0002, 32'h0000_1002, 32'h0000_1002, 2'd1};
    tbl[3] = '{4'b0000, 32'hA000_0000, 32'h0,         0, 2, 0, 32'h5555_AAAA, 32'h0000_0000, 32'hA000_0000, 2'd2};
    tbl[4] = '{4'b0000, 32'h9000_0003, 32'h0,         2, 1, 1, 32'hA5A5_0F0F, 32'h1000_0000, 32'h9000_0000, 2'd2};
    tbl[5] = '{4'b1111, 32'hC000_0008, 32'h0102_0304, 0, 0, 0, 32'h0000_0003, 32'hC000_0008, 32'hC000_0008, 2'd2};
    tbl[6] = '{4'b0011, 32'hA000_0102, 32'h0000_BEEF, 1, 1, 0, 32'h0000_0004, 32'h0000_0102, 32'hA000_0102, 2'd1};
    tbl[7] = '{4'b0001, 32'h7FFF_FFFF, 32'h0000_0077, 0, 0, 1, 32'h0000_0005, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'd0};
    tbl[8] = '{4'b0000, 32'h0000_0010, 32'h0,         0, 0, 0, 32'h8765_4321, 32'h0000_0010, 32'h0000_0010, 2'd2};

    rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    @(negedge clk);

    // table runs back-to-back: each new access issues the cycle after DONE
    for (int i = 0; i < 9; i++) run_access(tbl[i]);
    chk("req_queue_empty", req_q.size(), 32'd0);

    // reset while in WAIT, then a stray data_ok just after reset
    cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h8000_0100; mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    #1 chk("wait_stall", {31'd0, stall}, 32'd1);
    chk("wait_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    cpu_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hFEED_F00D;
    #1 chk("postrst_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    chk("postrst_stall", {31'd0, stall}, 32'd0);
    chk("postrst_mem_req2", {31'd0, mem_req}, 32'd0);
    chk("postrst_cpu_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    // a fresh access must see a clean IDLE bridge
    run_access('{4'b0000, 32'hBFC0_0004, 32'h0, 1, 0, 0, 32'h0BAD_CAFE,
                 32'h1FC0_0004, 32'hBFC0_0004, 2'd2});
    cpu_en = 1'b0;
    #1 chk("final_stall", {31'd0, stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
